game_menu_ctrl: RTL

GAME_MENU_CTRL -- requirements
Module: game_menu_ctrl

---
 rtl/game_menu_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/game_menu_ctrl.sv
// Game-select menu controller: debounces four raw buttons, moves a cursor over
// five games, launches the chosen game through a timed reset hold, and returns on home.
module game_menu_ctrl #(
  parameter int DB_CYCLES     = 1000000,
  parameter int LAUNCH_CYCLES = 16
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       up,
  input  logic       dn,
  input  logic       jump,
  input  logic       home,
  output logic [2:0] ctrl,
  output logic [2:0] cursor,
  output logic [4:0] game_rst,
  output logic       active,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int LW = $clog2(LAUNCH_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [LW-1:0] LAUNCH_LAST = LW'(LAUNCH_CYCLES - 1);

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    LAUNCH = 2'd1,
    PLAY   = 2'd2,
    EXIT   = 2'd3
  } state_t;

  state_t          state;
  logic [3:0]      raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      db;
  logic [3:0]      db_d;
  logic [CW-1:0]   db_cnt [4];
  logic [3:0]      press;
  logic [LW-1:0]   launch_cnt;
  logic            up_p, dn_p, jump_p, home_p;

  assign raw = {home, jump, dn, up};

  // Debounced level only moves after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press  = db & ~db_d;
  assign up_p   = press[0];
  assign dn_p   = press[1];
  assign jump_p = press[2];
  assign home_p = press[3];

  // Bit 4 is game 1, bit 0 is game 5; only the running game leaves reset.
  function automatic logic [4:0] run_mask(input logic [2:0] g);
    case (g)
      3'd1:    run_mask = 5'b01111;
      3'd2:    run_mask = 5'b10111;
      3'd3:    run_mask = 5'b11011;
      3'd4:    run_mask = 5'b11101;
      3'd5:    run_mask = 5'b11110;
      default: run_mask = 5'b11111;
    endcase
  endfunction

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state      <= MENU;
      cursor     <= 3'd1;
      ctrl       <= 3'd0;
      game_rst   <= 5'b11111;
      active     <= 1'b0;
      launch_cnt <= '0;
    end else begin
      case (state)
        MENU: begin
          if (jump_p) begin
            state      <= LAUNCH;
            ctrl       <= cursor;
            game_rst   <= 5'b11111;
            launch_cnt <= LAUNCH_LAST;
          end else if (up_p && !dn_p) begin
            cursor <= (cursor == 3'd1) ? 3'd5 : cursor - 3'd1;
          end else if (dn_p && !up_p) begin
            cursor <= (cursor == 3'd5) ? 3'd1 : cursor + 3'd1;
          end
        end
        LAUNCH: begin
          if (home_p) begin
            state    <= EXIT;
            ctrl     <= 3'd0;
            game_rst <= 5'b11111;
            active   <= 1'b0;
          end else if (launch_cnt == '0) begin
            state    <= PLAY;
            game_rst <= run_mask(ctrl);
            active   <= 1'b1;
          end else begin
            launch_cnt <= launch_cnt - 1'b1;
          end
        end
        PLAY: begin
          if (home_p) begin
            state    <= EXIT;
            ctrl     <= 3'd0;
            game_rst <= 5'b11111;
            active   <= 1'b0;
          end
        end
        default: state <= MENU;
      endcase
    end
  end

  assign state_dbg = state;

endmodule
